match_reporter: RTL and testbench

MATCH_REPORTER -- requirements
Module: match_reporter

---
 rtl/munch_pkg.sv | 20 ++
 rtl/match_reporter.sv | 127 ++++++++++++
 tb/tb_match_reporter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/munch_pkg.sv
// rtl/munch_pkg.sv - shared constants and reporter state encoding for the munch datapath
package munch_pkg;

    localparam int         MSG_W       = 152;
    localparam int         MSG_CHARS   = MSG_W / 8;
    localparam logic [7:0] ACK_MATCH   = 8'h4D;
    localparam logic [7:0] ACK_NOMATCH = 8'h4E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HDR,
        ST_POS_HI,
        ST_POS_LO,
        ST_CHAR,
        ST_CHAR_WAIT,
        ST_FIN
    } rpt_state_e;

endpackage

// File: rtl/match_reporter.sv
// rtl/match_reporter.sv - serialises a batch result (header, position, matched string) onto the host link
module match_reporter #(
    parameter int         MSG_CHARS   = munch_pkg::MSG_CHARS,
    parameter logic [7:0] ACK_MATCH   = munch_pkg::ACK_MATCH,
    parameter logic [7:0] ACK_NOMATCH = munch_pkg::ACK_NOMATCH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        proc_start,
    input  logic        proc_done,
    input  logic        proc_match,
    input  logic [15:0] proc_byte_pos,
    input  logic [7:0]  proc_match_char,
    output logic        proc_match_char_next,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rpt_busy,
    output logic        rpt_done
);
    import munch_pkg::*;

    localparam int CNT_W = $clog2(MSG_CHARS + 1);

    rpt_state_e  state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        match_q, match_d;
    logic [15:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        xfer;

    assign xfer = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        match_d    = match_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: ;
            ST_ARMED: begin
                if (proc_done) begin
                    match_d    = proc_match;
                    pos_d      = proc_byte_pos;
                    cnt_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = proc_match ? ACK_MATCH : ACK_NOMATCH;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    tx_data_d = pos_q[15:8];
                    state_d   = ST_POS_HI;
                end
            end
            ST_POS_HI: begin
                if (xfer) begin
                    tx_data_d = pos_q[7:0];
                    state_d   = ST_POS_LO;
                end
            end
            ST_POS_LO: begin
                if (xfer) begin
                    if (match_q) begin
                        tx_data_d = proc_match_char;
                        state_d   = ST_CHAR;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_FIN;
                    end
                end
            end
            ST_CHAR: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = ST_CHAR_WAIT;
                end
            end
            ST_CHAR_WAIT: begin
                // The matcher shifted during the transfer cycle, so the head char is fresh here.
                if (cnt_q == CNT_W'(MSG_CHARS)) begin
                    state_d = ST_FIN;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = proc_match_char;
                    state_d    = ST_CHAR;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (proc_start) begin
            state_d    = ST_ARMED;
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            match_q    <= 1'b0;
            pos_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            match_q    <= match_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_valid             = tx_valid_q;
    assign tx_data              = tx_data_q;
    assign proc_match_char_next = !reset && (state_q == ST_CHAR) && xfer;
    assign rpt_busy             = (state_q != ST_IDLE);
    assign rpt_done             = (state_q == ST_FIN);

endmodule

// File: tb/tb_match_reporter.sv
// tb/tb_match_reporter.sv - self-checking bench for match_reporter
module tb_match_reporter;
    import munch_pkg::*;

    localparam int N = MSG_CHARS;

    logic        clk = 1'b0;
    logic        reset;
    logic        proc_start;
    logic        proc_done;
    logic        proc_match;
    logic [15:0] proc_byte_pos;
    logic [7:0]  proc_match_char;
    logic        proc_match_char_next;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rpt_busy;
    logic        rpt_done;

    always #5 clk = ~clk;

    match_reporter dut (
        .clk                  (clk),
        .reset                (reset),
        .proc_start           (proc_start),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .proc_match_char_next (proc_match_char_next),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .rpt_busy             (rpt_busy),
        .rpt_done             (rpt_done)
    );

    // Shift-model matcher: head char is the top byte of msg shifted left by sh chars.
    logic [151:0] msg;
    logic [5:0]   sh;
    logic [151:0] shv;
    assign shv             = msg << {sh, 3'b000};
    assign proc_match_char = shv[151:144];

    always @(posedge clk) begin
        if (reset || proc_start) sh <= '0;
        else if (proc_match_char_next) sh <= sh + 6'd1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    byte unsigned got[$];
    int nexts, dones, first_v, done_cyc;
    logic pv = 1'b0, pr = 1'b0, ps = 1'b0, prst = 1'b1;
    logic [7:0] pd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
        if (proc_match_char_next === 1'b1) begin
            nexts++;
            chk("next_outside_xfer", {31'd0, tx_valid && tx_ready}, 32'd1);
        end
        if (rpt_done === 1'b1) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (tx_valid === 1'b1 && first_v < 0) first_v = cyc;
        if (pv && !pr && !ps && !prst) begin
            chk("hold_valid", {31'd0, tx_valid}, 32'd1);
            chk("hold_data", {24'd0, tx_data}, {24'd0, pd});
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data; ps = proc_start; prst = reset;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 13 >= 8) ? 1'b0 : (cyc % 2 == 0);
            2:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
        endcase
    endtask

    task automatic clear_rec();
        got.delete();
        nexts = 0; dones = 0; first_v = -1; done_cyc = -1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && dones == 0; i++) tick();
        chk("frame_done_seen", {31'd0, dones > 0}, 32'd1);
    endtask

    task automatic start_frame(input logic m, input logic [15:0] pos, input logic [151:0] s);
        msg = s;
        clear_rec();
        proc_start = 1'b1;
        proc_done  = 1'b0;
        tick();
        proc_start    = 1'b0;
        proc_done     = 1'b1;
        proc_match    = m;
        proc_byte_pos = pos;
    endtask

    task automatic check_frame(input string tag, input logic m, input logic [15:0] pos, input logic [151:0] s);
        byte unsigned exp[$];
        int n;
        exp.push_back(m ? 8'h4D : 8'h4E);
        exp.push_back(pos[15:8]);
        exp.push_back(pos[7:0]);
        if (m) for (int i = 0; i < N; i++) exp.push_back(s[151-8*i -: 8]);
        chk({tag, "_len"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
        chk({tag, "_nexts"}, nexts, m ? N : 0);
        chk({tag, "_dones"}, dones, 1);
    endtask

    logic [151:0] alpha;
    logic [151:0] rmsg;
    logic         rm;
    logic [15:0]  rpos;

    initial begin
        alpha         = "ABCDEFGHIJKLMNOPQRS";
        reset         = 1'b1;
        proc_start    = 1'b1;
        proc_done     = 1'b0;
        proc_match    = 1'b0;
        proc_byte_pos = 16'h0;
        tx_ready      = 1'b1;
        msg           = '0;
        clear_rec();
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_next", {31'd0, proc_match_char_next}, 32'd0);
        chk("rst_busy", {31'd0, rpt_busy}, 32'd0);
        chk("rst_done", {31'd0, rpt_done}, 32'd0);
        reset      = 1'b0;
        proc_start = 1'b0;
        tick();

        mode = 0;
        start_frame(1'b0, 16'h0400, alpha);
        wait_done();
        check_frame("nomatch", 1'b0, 16'h0400, alpha);

        start_frame(1'b1, 16'h0013, alpha);
        wait_done();
        check_frame("match", 1'b1, 16'h0013, alpha);
        chk("match_frame_cycles", done_cyc - first_v, 3 + 2 * N);

        mode = 1;
        start_frame(1'b1, 16'h0013, alpha);
        wait_done();
        check_frame("stall", 1'b1, 16'h0013, alpha);

        mode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) rmsg[151-8*i -: 8] = 8'($urandom_range(32, 126));
            rm   = 1'($urandom_range(0, 1));
            rpos = 16'($urandom);
            start_frame(rm, rpos, rmsg);
            wait_done();
            check_frame($sformatf("rand%0d", k), rm, rpos, rmsg);
        end

        mode = 0;
        tick();
        start_frame(1'b1, 16'h1234, alpha);
        for (int i = 0; i < 200 && !(got.size() == 6 && tx_valid); i++) tick();
        chk("abort_reached_char7", {31'd0, tx_valid}, 32'd1);
        proc_start = 1'b1;
        proc_done  = 1'b0;
        tick();
        proc_start = 1'b0;
        chk("abort_valid_low", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, rpt_busy}, 32'd1);
        chk("abort_state_armed", {29'd0, dut.state_q}, {29'd0, ST_ARMED});
        clear_rec();
        proc_done = 1'b1;
        wait_done();
        check_frame("abort_fresh", 1'b1, 16'h1234, alpha);

        clear_rec();
        proc_start    = 1'b1;
        proc_done     = 1'b1;
        proc_match    = 1'b0;
        proc_byte_pos = 16'h00AA;
        tick();
        proc_start = 1'b0;
        proc_done  = 1'b0;
        repeat (6) tick();
        chk("stale_no_valid", first_v, -1);
        chk("stale_still_busy", {31'd0, rpt_busy}, 32'd1);
        proc_done = 1'b1;
        wait_done();
        check_frame("stale", 1'b0, 16'h00AA, alpha);

        start_frame(1'b1, 16'h5678, alpha);
        for (int i = 0; i < 200 && !(got.size() == 2 && tx_valid); i++) tick();
        chk("rst_reached_poslo", {24'd0, tx_data}, 32'h78);
        reset = 1'b1;
        tick();
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("midrst_next", {31'd0, proc_match_char_next}, 32'd0);
        chk("midrst_busy", {31'd0, rpt_busy}, 32'd0);
        chk("midrst_done", {31'd0, rpt_done}, 32'd0);
        reset = 1'b0;
        clear_rec();
        repeat (8) tick();
        chk("midrst_no_done", dones, 0);
        chk("midrst_no_resume", first_v, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
